// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl
//   Button front-end for the watch's time-setting mode. Conditions the raw
//   mode/up/down buttons (2-flop synchroniser + debounce), walks a field-select
//   FSM on mode presses and issues single-cycle increment/decrement pulses
//   (with auto-repeat) towards the datetimes block.
// Ports
//   clk        system clock (1 kHz, same as datetimes)
//   rst        synchronous, active-low reset
//   btn_mode   raw mode button, active-high, asynchronous
//   btn_up     raw up button, active-high, asynchronous
//   btn_down   raw down button, active-high, asynchronous
//   set_mode   high in any SET state
//   sel_field  0=RUN 1=YEAR 2=MONTH 3=DAY 4=AP 5=HOUR 6=MIN 7=SEC
//   blink      toggles every BLINK_HALF cycles in SET states, 0 in RUN
//   i_*        increment pulses (y, mo, d, a, h, m, s)
//   d_*        decrement pulses (y, mo, d, h, m, s)
module watch_set_ctrl #(
  parameter int DEBOUNCE     = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int TIMEOUT      = 30000,
  parameter int BLINK_HALF   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       set_mode,
  output logic [2:0] sel_field,
  output logic       blink,
  output logic       i_y,
  output logic       i_mo,
  output logic       i_d,
  output logic       i_a,
  output logic       i_h,
  output logic       i_m,
  output logic       i_s,
  output logic       d_y,
  output logic       d_mo,
  output logic       d_d,
  output logic       d_h,
  output logic       d_m,
  output logic       d_s
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int RPW = $clog2(REP_MAX + 1);
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam int BKW = $clog2(BLINK_HALF + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE - 1);
  localparam logic [RPW-1:0] RP_DELAY = RPW'(REPEAT_DELAY);
  localparam logic [RPW-1:0] RP_RATE  = RPW'(REPEAT_RATE);
  localparam logic [TOW-1:0] TO_LAST  = TOW'(TIMEOUT - 1);
  localparam logic [BKW-1:0] BK_LAST  = BKW'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    YEAR  = 3'd1,
    MONTH = 3'd2,
    DAY   = 3'd3,
    AP    = 3'd4,
    HOUR  = 3'd5,
    MIN   = 3'd6,
    SEC   = 3'd7
  } state_e;

  // Button index: 0 = mode, 1 = up, 2 = down
  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]     lvl_q, lvl_d, press_q, press_d;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];

  state_e         state_q, state_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic [BKW-1:0] bk_cnt_q, bk_cnt_d;
  logic           blink_q, blink_d;
  logic           blk_q, blk_d;
  logic           rep_act_q, rep_act_d;
  logic           rep_up_q, rep_up_d;
  logic           rep_first_q, rep_first_d;
  logic [RPW-1:0] rep_cnt_q, rep_cnt_d;
  logic [12:0]    adj_q, adj_d;

  logic up_lvl, dn_lvl, both, any_press, in_set, chg, fire, fire_up;

  assign raw = {btn_down, btn_up, btn_mode};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    press_d = '0;
    for (int unsigned b = 0; b < 3; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != lvl_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          lvl_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    up_lvl    = lvl_q[1];
    dn_lvl    = lvl_q[2];
    both      = up_lvl & dn_lvl;
    any_press = |press_q;
    in_set    = (state_q != RUN);

    state_d = state_q;
    chg     = 1'b0;
    // SEC + 1 wraps the 3-bit encoding back to RUN
    if (press_q[0]) begin
      state_d = state_e'(state_q + 3'd1);
      chg     = 1'b1;
    end else if (in_set && !any_press && to_cnt_q == TO_LAST) begin
      state_d = RUN;
      chg     = 1'b1;
    end

    to_cnt_d = '0;
    if (in_set && !chg && !any_press && to_cnt_q != '1)
      to_cnt_d = to_cnt_q + TOW'(1);

    bk_cnt_d = '0;
    blink_d  = 1'b0;
    if (chg) begin
      blink_d = (state_d != RUN);
    end else if (in_set) begin
      if (bk_cnt_q == BK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        blink_d  = blink_q;
        bk_cnt_d = bk_cnt_q + BKW'(1);
      end
    end

    // A held button is locked out after a field change or an up+down overlap
    // until both buttons are released.
    blk_d = (up_lvl | dn_lvl) & (blk_q | both | chg);

    fire        = 1'b0;
    fire_up     = 1'b0;
    rep_act_d   = rep_act_q;
    rep_up_d    = rep_up_q;
    rep_first_d = rep_first_q;
    rep_cnt_d   = rep_cnt_q;
    if (chg || both || blk_q || !in_set) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (press_q[1] || press_q[2]) begin
      fire        = 1'b1;
      fire_up     = press_q[1];
      rep_act_d   = 1'b1;
      rep_up_d    = press_q[1];
      rep_first_d = 1'b1;
      rep_cnt_d   = RPW'(1);
    end else if (rep_act_q) begin
      if (rep_up_q ? up_lvl : dn_lvl) begin
        if (rep_cnt_q == (rep_first_q ? RP_DELAY : RP_RATE)) begin
          fire        = 1'b1;
          fire_up     = rep_up_q;
          rep_first_d = 1'b0;
          rep_cnt_d   = RPW'(1);
        end else if (rep_cnt_q != '1) begin
          rep_cnt_d = rep_cnt_q + RPW'(1);
        end
      end else begin
        rep_act_d = 1'b0;
        rep_cnt_d = '0;
      end
    end

    // adj bit order: i_y i_mo i_d i_a i_h i_m i_s d_y d_mo d_d d_h d_m d_s
    adj_d = '0;
    if (fire) begin
      case (state_q)
        YEAR:    adj_d[fire_up ? 0 : 7]  = 1'b1;
        MONTH:   adj_d[fire_up ? 1 : 8]  = 1'b1;
        DAY:     adj_d[fire_up ? 2 : 9]  = 1'b1;
        AP:      adj_d[3]                = 1'b1;
        HOUR:    adj_d[fire_up ? 4 : 10] = 1'b1;
        MIN:     adj_d[fire_up ? 5 : 11] = 1'b1;
        SEC:     adj_d[fire_up ? 6 : 12] = 1'b1;
        default: adj_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      press_q     <= '0;
      for (int unsigned b = 0; b < 3; b++) db_cnt_q[b] <= '0;
      state_q     <= RUN;
      to_cnt_q    <= '0;
      bk_cnt_q    <= '0;
      blink_q     <= 1'b0;
      blk_q       <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_first_q <= 1'b0;
      rep_cnt_q   <= '0;
      adj_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_q       <= lvl_d;
      press_q     <= press_d;
      for (int unsigned b = 0; b < 3; b++) db_cnt_q[b] <= db_cnt_d[b];
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      bk_cnt_q    <= bk_cnt_d;
      blink_q     <= blink_d;
      blk_q       <= blk_d;
      rep_act_q   <= rep_act_d;
      rep_up_q    <= rep_up_d;
      rep_first_q <= rep_first_d;
      rep_cnt_q   <= rep_cnt_d;
      adj_q       <= adj_d;
    end
  end

  assign set_mode  = (state_q != RUN);
  assign sel_field = state_q;
  assign blink     = blink_q;
  assign {d_s, d_m, d_h, d_d, d_mo, d_y, i_s, i_m, i_h, i_a, i_d, i_mo, i_y} = adj_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed scenarios plus random button activity,
// every cycle compared against a behavioural model of the button rules.
module tb_watch_set_ctrl;

  localparam int DB = 20;
  localparam int RD = 500;
  localparam int RR = 100;
  localparam int TO = 30000;
  localparam int BH = 250;

  logic clk = 1'b0;
  logic rst, btn_mode, btn_up, btn_down;
  logic set_mode, blink;
  logic [2:0] sel_field;
  logic i_y, i_mo, i_d, i_a, i_h, i_m, i_s, d_y, d_mo, d_d, d_h, d_m, d_s;
  logic [12:0] dut_adj;

  always #5 clk = ~clk;

  watch_set_ctrl #(
    .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .set_mode(set_mode), .sel_field(sel_field), .blink(blink),
    .i_y(i_y), .i_mo(i_mo), .i_d(i_d), .i_a(i_a), .i_h(i_h), .i_m(i_m), .i_s(i_s),
    .d_y(d_y), .d_mo(d_mo), .d_d(d_d), .d_h(d_h), .d_m(d_m), .d_s(d_s)
  );

  assign dut_adj = {d_s, d_m, d_h, d_d, d_mo, d_y, i_s, i_m, i_h, i_a, i_d, i_mo, i_y};

  // ---------------- reference model ----------------
  int   hist [3][DB+1];   // hist[b][j] = raw sample from j+1 edges ago
  bit   mlvl [3];
  bit   mpp  [3];
  int   edge_n = 0;
  int   field = 0, entry_e = 0, last_act = 0, rep = -1, next_rep = 0;
  bit   blocked = 0;
  logic [2:0]  exp_sel = '0;
  logic        exp_set = 1'b0, exp_blink = 1'b0;
  logic [12:0] exp_adj = '0;

  always @(posedge clk) begin
    bit anyp, lu, ld, both, chg, blk_old, flip;
    int fire, idx;
    logic [12:0] one;
    bit [2:0] rawv;
    edge_n++;
    if (!rst) begin
      for (int b = 0; b < 3; b++) begin
        mlvl[b] = 0; mpp[b] = 0;
        for (int j = 0; j <= DB; j++) hist[b][j] = 0;
      end
      field = 0; rep = -1; blocked = 0; last_act = edge_n; entry_e = edge_n;
      exp_sel = '0; exp_set = 0; exp_blink = 0; exp_adj = '0;
    end else begin
      anyp = mpp[0] | mpp[1] | mpp[2];
      lu = mlvl[1]; ld = mlvl[2]; both = lu && ld;
      chg = 0; fire = -1;
      if (mpp[0]) begin field = (field + 1) % 8; chg = 1; end
      else if (field != 0 && !anyp && (edge_n - last_act) == TO) begin field = 0; chg = 1; end
      if (chg) entry_e = edge_n;
      if (chg || anyp) last_act = edge_n;
      blk_old = blocked;
      if (!lu && !ld) blocked = 0;
      else if (chg || both) blocked = 1;
      if (chg || both || blk_old || field == 0) rep = -1;
      else if (mpp[1]) begin fire = 1; rep = 1; next_rep = edge_n + RD; end
      else if (mpp[2]) begin fire = 2; rep = 2; next_rep = edge_n + RD; end
      else if (rep > 0) begin
        if (mlvl[rep]) begin
          if (edge_n == next_rep) begin fire = rep; next_rep = edge_n + RR; end
        end else rep = -1;
      end
      one = 13'd1;
      if (fire < 0) exp_adj = '0;
      else begin
        if (fire == 1 || field == 4) idx = field - 1;
        else idx = (field < 4) ? field + 6 : field + 5;
        exp_adj = one << idx;
      end
      exp_sel   = 3'(field);
      exp_set   = (field != 0);
      exp_blink = (field != 0) && (((edge_n - entry_e) / BH) % 2 == 0);
      // debounce: flip when the last DB synchronised samples all disagree
      rawv = {btn_down, btn_up, btn_mode};
      for (int b = 0; b < 3; b++) begin
        flip = 1;
        for (int j = 1; j <= DB; j++) if (hist[b][j] == int'(mlvl[b])) flip = 0;
        mpp[b] = 0;
        if (flip) begin mlvl[b] = !mlvl[b]; mpp[b] = mlvl[b]; end
        for (int j = DB; j >= 1; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = int'(rawv[b]);
      end
    end
  end

  // ---------------- checking ----------------
  int ncmp = 0, nfail = 0, cyc_n = 0;
  int pl_cyc[$];
  int pl_idx[$];

  task automatic check_all();
    ncmp++;
    assert (sel_field === exp_sel) else begin
      nfail++; $error("FAIL sel_field got=%0d exp=%0d cyc=%0d", sel_field, exp_sel, cyc_n);
    end
    ncmp++;
    assert (set_mode === exp_set) else begin
      nfail++; $error("FAIL set_mode got=%0b exp=%0b cyc=%0d", set_mode, exp_set, cyc_n);
    end
    ncmp++;
    assert (blink === exp_blink) else begin
      nfail++; $error("FAIL blink got=%0b exp=%0b cyc=%0d", blink, exp_blink, cyc_n);
    end
    ncmp++;
    assert (dut_adj === exp_adj) else begin
      nfail++; $error("FAIL adjust got=%b exp=%b cyc=%0d", dut_adj, exp_adj, cyc_n);
    end
    for (int i = 0; i < 13; i++)
      if (dut_adj[i] === 1'b1) begin pl_cyc.push_back(cyc_n); pl_idx.push_back(i); end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc_n++;
      check_all();
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic press(input int b, input int hold, input int gap);
    if (b == 0) btn_mode = 1; else if (b == 1) btn_up = 1; else btn_down = 1;
    tick(hold);
    btn_mode = 0; btn_up = 0; btn_down = 0;
    tick(gap);
  endtask

  task automatic clear_log();
    pl_cyc.delete(); pl_idx.delete();
  endtask

  int t, t0, r, a, bb;

  initial begin
    rst = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
    tick(3);
    chk("reset_sel", int'(sel_field), 0);
    rst = 1;
    tick(2);

    // mode press latency into YEAR
    btn_mode = 1; t = 0;
    while (set_mode !== 1'b1 && t < 100) begin tick(1); t++; end
    chk("mode_latency", t, 23);
    chk("mode_sel_year", int'(sel_field), 1);
    if (t < 30) tick(30 - t);
    btn_mode = 0;
    tick(600);                                  // blink toggling checked each cycle
    for (int k = 0; k < 4; k++) press(0, 30, 30); // -> HOUR

    // HOUR: long down hold, auto-repeat
    clear_log(); t0 = cyc_n; btn_down = 1;
    tick(800); btn_down = 0; tick(100);
    chk("hour_pulses", pl_cyc.size(), 4);
    if (pl_cyc.size() == 4) begin
      chk("hour_first", pl_cyc[0] - t0, 23);
      chk("hour_gap1", pl_cyc[1] - pl_cyc[0], RD);
      chk("hour_gap2", pl_cyc[2] - pl_cyc[1], RR);
      chk("hour_gap3", pl_cyc[3] - pl_cyc[2], RR);
      chk("hour_idx", pl_idx[0], 10);
    end

    // MIN: short up hold, one pulse
    press(0, 30, 30);
    clear_log(); press(1, 30, 40);
    chk("min_pulses", pl_cyc.size(), 1);
    if (pl_cyc.size() == 1) chk("min_idx", pl_idx[0], 5);

    // AP: down increments
    for (int k = 0; k < 6; k++) press(0, 30, 30);
    clear_log(); press(2, 30, 40);
    chk("ap_pulses", pl_cyc.size(), 1);
    if (pl_cyc.size() == 1) chk("ap_idx", pl_idx[0], 3);

    // RUN: up ignored
    for (int k = 0; k < 4; k++) press(0, 30, 30);
    clear_log(); press(1, 60, 40);
    chk("run_pulses", pl_cyc.size(), 0);

    // YEAR: bounce then stable press
    press(0, 30, 30);
    clear_log();
    for (int k = 0; k < 20; k++) begin btn_up = ~btn_up; tick(5); end
    btn_up = 1; t0 = cyc_n; tick(60); btn_up = 0; tick(40);
    chk("bounce_pulses", pl_cyc.size(), 1);
    if (pl_cyc.size() == 1) chk("bounce_latency", pl_cyc[0] - t0, 23);

    // reset mid-repeat
    btn_up = 1; tick(600);
    rst = 0; tick(1);
    chk("rst_set_mode", int'(set_mode), 0);
    chk("rst_adjust", int'(dut_adj), 0);
    rst = 1; clear_log(); tick(300); btn_up = 0; tick(40);
    chk("post_rst_pulses", pl_cyc.size(), 0);

    // random button activity
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) press(0, $urandom_range(20, 60), $urandom_range(1, 60));
      else if (r <= 5) press(1, $urandom_range(1, 800), $urandom_range(1, 60));
      else if (r <= 7) press(2, $urandom_range(1, 800), $urandom_range(1, 60));
      else if (r == 8) begin
        btn_up = 1; tick($urandom_range(1, 600));
        btn_down = 1; tick($urandom_range(1, 200));
        if ($urandom_range(0, 1) == 1) btn_up = 0; else btn_down = 0;
        tick($urandom_range(1, 300));
        btn_up = 0; btn_down = 0; tick($urandom_range(1, 60));
      end else begin
        bb = $urandom_range(0, 2);
        for (int k = 0; k < 10; k++) begin
          a = $urandom_range(1, 25);
          if (bb == 0) btn_mode = ~btn_mode; else if (bb == 1) btn_up = ~btn_up; else btn_down = ~btn_down;
          tick(a);
        end
        btn_mode = 0; btn_up = 0; btn_down = 0; tick($urandom_range(1, 60));
      end
    end

    // SEC then idle timeout
    for (int k = 0; k < 10 && field != 7; k++) press(0, 30, 30);
    chk("sec_reached", int'(sel_field), 7);
    tick(TO + 10);
    chk("timeout_sel", int'(sel_field), 0);
    chk("timeout_set_mode", int'(set_mode), 0);
    chk("timeout_blink", int'(blink), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
